// File: rtl/div_n_or_n1_if.sv
// rtl/div_n_or_n1_if.sv - control/status bundle for the dual-modulus clock divider
interface div_n_or_n1_if #(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 8
);
    logic              en;
    logic [WIDTH-1:0]  div_n;
    logic              mod;
    logic              clk_out;
    logic              tc;
    logic [WIDTH:0]    ratio_o;
    logic [PCNT_W-1:0] pcnt;

    modport master (
        output en, div_n, mod,
        input  clk_out, tc, ratio_o, pcnt
    );

    modport slave (
        input  en, div_n, mod,
        output clk_out, tc, ratio_o, pcnt
    );
endinterface

// File: rtl/div_n_or_n1.sv
// rtl/div_n_or_n1.sv - divide clk_in by N or N+1, ratio switched only at period boundaries
module div_n_or_n1 #(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 8
) (
    input  logic          clk_in,
    input  logic          rst,
    div_n_or_n1_if.slave  bus
);
    localparam int RW = WIDTH + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     r_lat_q, r_lat_d;
    logic              clk_out_q, clk_out_d;
    logic              tc_q, tc_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;

    logic [RW-1:0]     neff;
    logic [RW-1:0]     r_new;
    logic [RW:0]       hi;
    logic [RW:0]       cnt_inc;
    logic              period_end;

    // Extra bit on hi/cnt_inc keeps R = 2^WIDTH from wrapping.
    always_comb begin
        neff       = ({1'b0, bus.div_n} < RW'(2)) ? RW'(2) : {1'b0, bus.div_n};
        r_new      = neff + RW'(bus.mod);
        hi         = ({1'b0, r_lat_q} + (RW+1)'(1)) >> 1;
        cnt_inc    = {1'b0, cnt_q} + (RW+1)'(1);
        period_end = (cnt_q == (r_lat_q - RW'(1)));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        r_lat_d   = r_lat_q;
        clk_out_d = clk_out_q;
        tc_d      = 1'b0;
        pcnt_d    = pcnt_q;

        if (bus.en) begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    r_lat_d   = r_new;
                    clk_out_d = 1'b1;
                    tc_d      = 1'b1;
                end
                ST_RUN: begin
                    if (period_end) begin
                        cnt_d     = '0;
                        r_lat_d   = r_new;
                        clk_out_d = 1'b1;
                        tc_d      = 1'b1;
                        pcnt_d    = pcnt_q + PCNT_W'(1);
                    end else begin
                        cnt_d     = cnt_inc[RW-1:0];
                        clk_out_d = (cnt_inc < hi);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            r_lat_q   <= '0;
            clk_out_q <= 1'b0;
            tc_q      <= 1'b0;
            pcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            r_lat_q   <= r_lat_d;
            clk_out_q <= clk_out_d;
            tc_q      <= tc_d;
            pcnt_q    <= pcnt_d;
        end
    end

    assign bus.clk_out = clk_out_q;
    assign bus.tc      = tc_q;
    assign bus.ratio_o = r_lat_q;
    assign bus.pcnt    = pcnt_q;
endmodule

// File: tb/tb_div_n_or_n1.sv
// tb/tb_div_n_or_n1.sv - self-checking bench for div_n_or_n1
module tb_div_n_or_n1;
    localparam int WIDTH  = 4;
    localparam int PCNT_W = 8;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    div_n_or_n1_if #(.WIDTH(WIDTH), .PCNT_W(PCNT_W)) bus ();

    div_n_or_n1 #(.WIDTH(WIDTH), .PCNT_W(PCNT_W)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Reference: position within the current period and the period's ratio.
    bit m_run;
    int m_pos, m_r, m_pcnt;
    bit m_tc;

    typedef struct {
        bit en;
        int div_n;
        bit md;
        bit clk;
        bit tc;
        int ratio;
        int pcnt;
    } vec_t;

    vec_t tv[16];
    logic [31:0] pat;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ratio_of(input int n, input int m);
        return ((n < 2) ? 2 : n) + m;
    endfunction

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_r = 0; m_pcnt = 0; m_tc = 0;
    endtask

    task automatic model_edge();
        if (!bus.en) begin
            m_tc = 0;
        end else if (!m_run) begin
            m_run = 1; m_pos = 0; m_r = ratio_of(bus.div_n, bus.mod); m_tc = 1;
        end else begin
            m_pos++;
            if (m_pos == m_r) begin
                m_pos  = 0;
                m_pcnt = (m_pcnt + 1) % (1 << PCNT_W);
                m_r    = ratio_of(bus.div_n, bus.mod);
                m_tc   = 1;
            end else begin
                m_tc = 0;
            end
        end
    endtask

    task automatic step();
        int exp_clk;
        @(posedge clk_in);
        #1;
        model_edge();
        exp_clk = (m_run && (m_pos < (m_r + 1) / 2)) ? 1 : 0;
        chk("model clk_out", int'(bus.clk_out), exp_clk);
        chk("model tc", int'(bus.tc), int'(m_tc));
        chk("model ratio_o", int'(bus.ratio_o), m_r);
        chk("model pcnt", int'(bus.pcnt), m_pcnt);
        pat = {pat[30:0], bus.clk_out};
    endtask

    // Asynchronous pulse placed between clock edges.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst clk_out", int'(bus.clk_out), 0);
        chk("rst tc", int'(bus.tc), 0);
        chk("rst ratio_o", int'(bus.ratio_o), 0);
        chk("rst pcnt", int'(bus.pcnt), 0);
        #2 rst = 1'b0;
    endtask

    task automatic set_in(input bit e, input int n, input bit m);
        bus.en = e; bus.div_n = WIDTH'(n); bus.mod = m;
    endtask

    initial begin
        for (int i = 0; i < 12; i++)
            tv[i] = '{1, 3, 0, (i % 3) != 2, (i % 3) == 0, 3, i / 3};
        tv[12] = '{1, 1, 0, 1, 1, 2, 4};
        tv[13] = '{1, 1, 0, 0, 0, 2, 4};
        tv[14] = '{1, 1, 0, 1, 1, 2, 5};
        tv[15] = '{0, 1, 0, 1, 0, 2, 5};

        set_in(0, 3, 0);
        pat = '0;
        model_reset();
        #12;
        chk("init clk_out", int'(bus.clk_out), 0);
        chk("init tc", int'(bus.tc), 0);
        chk("init ratio_o", int'(bus.ratio_o), 0);
        chk("init pcnt", int'(bus.pcnt), 0);
        rst = 1'b0;

        // Table: R=3 from start, then clamped div_n=1, then a frozen cycle
        for (int i = 0; i < 16; i++) begin
            set_in(tv[i].en, tv[i].div_n, tv[i].md);
            step();
            chk($sformatf("tv%0d clk_out", i), int'(bus.clk_out), int'(tv[i].clk));
            chk($sformatf("tv%0d tc", i), int'(bus.tc), int'(tv[i].tc));
            chk($sformatf("tv%0d ratio_o", i), int'(bus.ratio_o), tv[i].ratio);
            chk($sformatf("tv%0d pcnt", i), int'(bus.pcnt), tv[i].pcnt);
        end

        // mod toggled mid-period: 1100 110 1100
        do_reset();
        set_in(1, 3, 1);
        pat = '0;
        for (int i = 0; i < 11; i++) begin
            step();
            if (i == 1) bus.mod = 1'b0;
            if (i == 3) chk("modsw ratio end p1", int'(bus.ratio_o), 4);
            if (i == 5) bus.mod = 1'b1;
            if (i == 6) chk("modsw ratio p2", int'(bus.ratio_o), 3);
            if (i == 7) chk("modsw ratio p3", int'(bus.ratio_o), 4);
        end
        chk("modsw pattern", int'(pat[10:0]), int'(11'b11001101100));

        // R=5, then div_n=0 clamp: 11100 10 10 110
        do_reset();
        set_in(1, 4, 1);
        pat = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 2) begin bus.div_n = '0; bus.mod = 1'b0; end
            if (i == 7) bus.mod = 1'b1;
        end
        chk("r5 clamp pattern", int'(pat[11:0]), int'(12'b111001010110));

        // Max ratio R=16
        do_reset();
        set_in(1, 15, 1);
        pat = '0;
        for (int i = 0; i < 16; i++) step();
        chk("r16 pattern", int'(pat[15:0]), 16'hFF00);
        chk("r16 ratio_o", int'(bus.ratio_o), 16);

        // en low at cnt=1 with R=4
        do_reset();
        set_in(1, 3, 1);
        step(); step();
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("freeze clk_out", int'(bus.clk_out), 1);
            chk("freeze tc", int'(bus.tc), 0);
            chk("freeze ratio_o", int'(bus.ratio_o), 4);
        end
        bus.en = 1'b1;
        step(); chk("resume cnt2 clk", int'(bus.clk_out), 0); chk("resume cnt2 tc", int'(bus.tc), 0);
        step(); chk("resume cnt3 clk", int'(bus.clk_out), 0); chk("resume cnt3 tc", int'(bus.tc), 0);
        step(); chk("resume end tc", int'(bus.tc), 1); chk("resume end pcnt", int'(bus.pcnt), 1);

        // pcnt wrap, then async reset mid-period and restart
        do_reset();
        set_in(1, 0, 0);
        for (int i = 0; i < 511; i++) step();
        chk("wrap pcnt 255", int'(bus.pcnt), 255);
        step(); step();
        chk("wrap pcnt 0", int'(bus.pcnt), 0);
        step();
        do_reset();
        step();
        chk("restart clk_out", int'(bus.clk_out), 1);
        chk("restart tc", int'(bus.tc), 1);
        chk("restart pcnt", int'(bus.pcnt), 0);

        // Random inputs every cycle against the reference
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            set_in(($urandom_range(0, 7) != 0), $urandom_range(0, 15), $urandom_range(0, 1) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
